bpsk_frame_scheduler: RTL and testbench

- Sequences framed transmissions into one BPSK modulator: preamble, sync byte, length byte, payload read from the 256-byte RAM, then a check byte.
- Drives the modulator's byte input, paces itself on the modulator's per-byte done pulse, and gates the modulator's enable.
- Sits between the top-level command controller (start/stop/loop) and the shared RAM/modulator pair, replacing ad-hoc address stepping in RUN mode.

---
 rtl/bpsk_sched_pkg.sv | 29 ++
 rtl/bpsk_sched_check.sv | 34 +++
 rtl/bpsk_frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_bpsk_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_sched_pkg.sv
// Shared types and constants for the BPSK frame scheduler.
// The CRC-8 helper is used when BPSK_SCHED_CRC8_EN is defined.
package bpsk_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_LEN      = 3'd3,
    ST_PAYLOAD  = 3'd4,
    ST_CHECK    = 3'd5,
    ST_GAP      = 3'd6
  } sched_state_e;

  localparam logic [7:0] DEF_PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] DEF_SYNC_BYTE     = 8'h7E;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // One byte of MSB-first CRC-8, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/bpsk_sched_check.sv
// Frame check accumulator: XOR by default, CRC-8 when BPSK_SCHED_CRC8_EN is defined.
// 'value' already includes 'data' in a cycle where 'acc' is high.
module bpsk_sched_check
  import bpsk_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       acc,
  input  logic [7:0] data,
  output logic [7:0] value
);

  logic [7:0] check_reg;
  logic [7:0] stepped;

  always_comb begin
`ifdef BPSK_SCHED_CRC8_EN
    stepped = crc8_update(check_reg, data);
`else
    stepped = check_reg ^ data;
`endif
    value = acc ? stepped : check_reg;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      check_reg <= 8'h00;
    end else if (acc) begin
      check_reg <= stepped;
    end
  end

endmodule

// File: rtl/bpsk_frame_scheduler.sv
// Frame sequencer for the BPSK modulator: preamble, sync, length, RAM payload, check byte.
// Check byte type is selected by BPSK_SCHED_CRC8_EN (CRC-8) or left undefined (XOR).
module bpsk_frame_scheduler
  import bpsk_sched_pkg::*;
#(
  parameter int         PREAMBLE_LEN  = 4,
  parameter logic [7:0] PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         GAP_LEN       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [7:0]  payload_len,
  input  logic        byte_done,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  mem_addr,
  output logic [7:0]  byte_out,
  output logic        mod_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state_out
);

  sched_state_e state;
  logic [7:0]   len_reg;
  logic [3:0]   cnt;
  logic         stop_lat;
  logic [7:0]   chk_value;
  logic         end_req, pre_last, gap_last, pay_last, chk_acc, restart;

  assign end_req  = stop_lat || !loop_en;
  assign pre_last = (cnt == 4'(PREAMBLE_LEN - 1));
  assign gap_last = (cnt == 4'(GAP_LEN - 1));
  assign pay_last = (mem_addr == len_reg);
  assign chk_acc  = byte_done && (state == ST_LEN || state == ST_PAYLOAD);
  assign busy      = (state != ST_IDLE);
  assign state_out = state;

  // A new frame begins from IDLE on start, or back-to-back when looping.
  always_comb begin
    restart = 1'b0;
    if (state == ST_IDLE) begin
      restart = start && !stop;
    end else if (byte_done && !end_req) begin
      if (state == ST_CHECK) begin
        restart = (GAP_LEN == 0);
      end else if (state == ST_GAP) begin
        restart = gap_last;
      end
    end
  end

  bpsk_sched_check u_check (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .acc   (chk_acc),
    .data  (byte_out),
    .value (chk_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_out   <= 8'h00;
      mem_addr   <= 8'h00;
      mod_en     <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
      len_reg    <= 8'h00;
      cnt        <= 4'd0;
      stop_lat   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (stop && state != ST_IDLE) begin
        stop_lat <= 1'b1;
      end
      if (byte_done) begin
        case (state)
          ST_PREAMBLE: begin
            if (pre_last) begin
              state    <= ST_SYNC;
              byte_out <= SYNC_BYTE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ST_SYNC: begin
            state    <= ST_LEN;
            byte_out <= len_reg;
          end
          ST_LEN: begin
            if (len_reg == 8'h00) begin
              state    <= ST_CHECK;
              byte_out <= chk_value;
            end else begin
              state    <= ST_PAYLOAD;
              byte_out <= mem_rd_data;
              mem_addr <= 8'd1;
            end
          end
          // mem_addr runs one ahead of the byte on air, so it equals len_reg on the last byte.
          ST_PAYLOAD: begin
            if (pay_last) begin
              state    <= ST_CHECK;
              byte_out <= chk_value;
            end else begin
              byte_out <= mem_rd_data;
              mem_addr <= mem_addr + 8'd1;
            end
          end
          ST_CHECK: begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            if (end_req) begin
              state    <= ST_IDLE;
              mod_en   <= 1'b0;
              byte_out <= 8'h00;
              stop_lat <= 1'b0;
            end else if (GAP_LEN > 0) begin
              state    <= ST_GAP;
              byte_out <= 8'h00;
              cnt      <= 4'd0;
            end
          end
          ST_GAP: begin
            if (gap_last) begin
              if (end_req) begin
                state    <= ST_IDLE;
                mod_en   <= 1'b0;
                byte_out <= 8'h00;
                stop_lat <= 1'b0;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
      if (restart) begin
        state    <= ST_PREAMBLE;
        byte_out <= PREAMBLE_BYTE;
        mod_en   <= 1'b1;
        len_reg  <= payload_len;
        mem_addr <= 8'h00;
        cnt      <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Scoreboard bench for bpsk_frame_scheduler: expected bytes are queued per frame and
// compared as the modelled modulator consumes them.
`timescale 1ns/1ps
module tb_bpsk_frame_scheduler;

  localparam logic [7:0] PRE_B  = 8'hAA;
  localparam logic [7:0] SYNC_B = 8'h7E;
  localparam int         PRE_N  = 4;
  localparam int         GAP_N  = 2;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, byte_done;
  logic [7:0]  payload_len, mem_rd_data, mem_addr, byte_out;
  logic        mod_en, busy, frame_done;
  logic [15:0] frame_cnt;
  logic [2:0]  state_out;

  logic [7:0]  ram [256];
  logic [7:0]  exp_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          done_en = 1'b0;
  int          done_period = 20;
  int          done_gap = 0;
  logic [7:0]  addr_max = 8'h00;

  bpsk_frame_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .payload_len (payload_len),
    .byte_done   (byte_done),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .byte_out    (byte_out),
    .mod_en      (mod_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= ram[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] checkStep(input logic [7:0] c, input logic [7:0] d);
`ifdef BPSK_SCHED_CRC8_EN
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
`else
    return c ^ d;
`endif
  endfunction

  // Queue the complete byte sequence of one frame, optionally followed by the gap.
  task automatic applyStimulus(input int len, input bit with_gap);
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 0; i < PRE_N; i++) exp_q.push_back(PRE_B);
    exp_q.push_back(SYNC_B);
    exp_q.push_back(8'(len));
    chk = checkStep(chk, 8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(ram[i]);
      chk = checkStep(chk, ram[i]);
    end
    exp_q.push_back(chk);
    if (with_gap) for (int i = 0; i < GAP_N; i++) exp_q.push_back(8'h00);
  endtask

  // Modulator model: paces byte_done and scores each consumed byte.
  initial begin
    byte_done = 1'b0;
    forever begin
      @(negedge clk);
      byte_done = 1'b0;
      if (mod_en === 1'b1 && mem_addr > addr_max) addr_max = mem_addr;
      if (done_en && mod_en === 1'b1) begin
        done_gap++;
        if (done_gap >= done_period) begin
          done_gap  = 0;
          byte_done = 1'b1;
          checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) checkOutput("byte_out", 32'(byte_out), 32'(exp_q.pop_front()));
        end
      end else begin
        done_gap = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic doReset();
    done_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    addr_max = 8'h00;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (state_out == s) seen = 1'b1;
    end
    checkOutput("reach_state", 32'(seen), 32'd1);
  endtask

  task automatic waitPayload(input logic [15:0] cnt, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_cnt == cnt && state_out == 3'd4) seen = 1'b1;
    end
    checkOutput("reach_payload", 32'(seen), 32'd1);
  endtask

  task automatic waitFrameDone(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checkOutput("frame_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("mod_en_at_done", 32'(mod_en), 32'd0);
      checkOutput("idle_at_done", 32'(state_out), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; payload_len = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    repeat (3) @(negedge clk);
    checkOutput("rst_state", 32'(state_out), 32'd0);
    checkOutput("rst_byte_out", 32'(byte_out), 32'd0);
    checkOutput("rst_mod_en", 32'(mod_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Two-byte payload, single frame; start during SYNC must be ignored.
    ram[0] = 8'h12; ram[1] = 8'h34; payload_len = 8'd2; loop_en = 1'b0;
    done_period = 20;
    applyStimulus(2, 1'b0);
    done_en = 1'b1;
    pulseStart();
    checkOutput("start_state", 32'(state_out), 32'd1);
    checkOutput("start_byte_out", 32'(byte_out), 32'(PRE_B));
    checkOutput("start_mod_en", 32'(mod_en), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    waitState(3'd2, 400);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checkOutput("busy_start_state", 32'(state_out), 32'd2);
    checkOutput("busy_start_byte", 32'(byte_out), 32'(SYNC_B));
    waitFrameDone(1000);
    checkOutput("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("f1_drained", 32'(exp_q.size()), 32'd0);

    // start and stop together in IDLE start nothing.
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    checkOutput("ss_state", 32'(state_out), 32'd0);
    checkOutput("ss_mod_en", 32'(mod_en), 32'd0);

    // Zero-length payload: check byte follows length, RAM never addressed.
    doReset();
    payload_len = 8'd0;
    applyStimulus(0, 1'b0);
    done_en = 1'b1;
    pulseStart();
    waitFrameDone(1000);
    checkOutput("len0_addr_max", 32'(addr_max), 32'd0);
    checkOutput("len0_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("len0_frame_cnt", 32'(frame_cnt), 32'd1);

    // Looping with gap; stop in frame 2 payload ends it at its check byte.
    doReset();
    ram[0] = 8'h5A; payload_len = 8'd1; loop_en = 1'b1;
    applyStimulus(1, 1'b1);
    applyStimulus(1, 1'b0);
    done_en = 1'b1;
    pulseStart();
    waitPayload(16'd1, 2000);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    waitFrameDone(1000);
    checkOutput("loop_frame_cnt", 32'(frame_cnt), 32'd2);
    checkOutput("loop_drained", 32'(exp_q.size()), 32'd0);
    loop_en = 1'b0;

    // Reset in the middle of a payload aborts immediately.
    doReset();
    ram[0] = 8'hC3; ram[1] = 8'h3C; ram[2] = 8'h99; payload_len = 8'd3; loop_en = 1'b1;
    applyStimulus(3, 1'b1);
    applyStimulus(3, 1'b1);
    done_en = 1'b1;
    pulseStart();
    waitPayload(16'd1, 2000);
    done_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_state", 32'(state_out), 32'd0);
    checkOutput("mid_rst_mod_en", 32'(mod_en), 32'd0);
    checkOutput("mid_rst_byte_out", 32'(byte_out), 32'd0);
    checkOutput("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    loop_en = 1'b0;

    // Maximum payload length: addresses 0..254 read in order, no wrap.
    doReset();
    for (int i = 0; i < 255; i++) ram[i] = 8'(i * 7 + 3);
    payload_len = 8'd255;
    done_period = 3;
    applyStimulus(255, 1'b0);
    done_en = 1'b1;
    pulseStart();
    waitFrameDone(3000);
    checkOutput("max_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("max_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("max_addr_reach", 32'(addr_max >= 8'd254), 32'd1);

    done_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
